alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Control-side initiator for the accumulator/ALU datapath block. It accepts one ALU micro-operation request at a time from instruction decode and drives the datapath strobes in the proper cycle order: ACT/TMP load, ALU select hold, accumulator writeback and result-to-bus. It also owns the 8085 flag register: it captures ALU flag outputs, and loads or drives the flag byte for the PSW push/pop path.

Parameters:
FLAG_RESET, 8'h02, flag register value after reset (bit1 is always 1).
CY_INV, 0, when 1 the captured CY is the inverse of alu_carry (borrow convention).

Ports:
phi1  in  1  clock; all state updates on posedge phi1.
rst  in  1  synchronous active-high reset, sampled on posedge phi1.
req_valid  in  1  request present.
req_ready  out  1  sequencer can accept a request.
req_kind  in  3  0=ALU_A, 1=ALU_CMP, 2=INR_DCR, 3=PUSH_PSW, 4=POP_PSW, 5-7=NOP.
req_sel  in  5  {select_op1,select_op2,select_neg,select_ncarry_1,select_shift_right} for the op.
req_dec  in  1  INR_DCR only: 0=increment (ACT=00), 1=decrement (ACT=FE).
done  out  1  one-cycle pulse in the final cycle of an operation.
alu_sel  out  5  held select word to the ALU, same bit order as req_sel.
dbus_to_act, a_to_act, write_dbus_to_alu_tmp, alu_to_a, sel_alu_a, alu_a_to_dbus, sel_0_fe, fe_0_to_act  out  1 each  datapath strobes.
alu_msb, alu_zero, alu_parity, alu_carry, alu_aux  in  1 each  ALU result bit7 and flag outputs.
flag_in  in  8  flag byte from the data bus (POP PSW).
flag_out  out  8  current flag register.
flag_oe  out  1  flag_out drives the flag bus this cycle.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - Flags load FLAG_RESET; alu_sel loads 0.
  - All strobes, done and flag_oe are 0. req_ready is 1 in the cycle after reset.
  - A reset asserted in any state aborts the operation. No writeback and no flag update occur for the aborted operation.
- States: IDLE, LOAD, EXEC, FLAG. All strobes are decoded combinationally from the state register and latched kind/dec. Strobes are 0 in every state not listed below.
- IDLE:
  - req_ready=1.
  - On req_valid, the request is accepted at the edge: kind, dec and sel are latched, and alu_sel is updated.
  - kind 0-2 go to LOAD; kind 3-4 go to FLAG; NOP goes to FLAG with no side effect.
- LOAD (one cycle):
  - write_dbus_to_alu_tmp=1 for all ALU kinds; the operand must be valid on the bus this cycle.
  - ALU_A and ALU_CMP: a_to_act=1.
  - INR_DCR: sel_0_fe=1 and fe_0_to_act=req_dec.
  - Next state is EXEC.
- EXEC (one cycle):
  - done=1.
  - ALU_A: alu_to_a=1.
  - INR_DCR: sel_alu_a=1 and alu_a_to_dbus=1.
  - ALU_CMP: no A write.
  - Flags are captured at the end of EXEC: S=alu_msb, Z=alu_zero, AC=alu_aux, P=alu_parity, CY=alu_carry^CY_INV.
  - INR_DCR preserves CY.
  - Next state is IDLE.
- FLAG (one cycle):
  - done=1.
  - PUSH_PSW: flag_oe=1 and flag_out=flags.
  - POP_PSW: at end of cycle, flags=(flag_in & 8'hD7) | 8'h02.
  - Next state is IDLE.
- Flag layout: {S,Z,0,AC,0,P,1,CY}. Bits 5 and 3 are always 0 and bit 1 is always 1.
- Latency from the accept edge: ALU kinds take 2 cycles (done in the 2nd); flag kinds and NOP take 1 cycle.
- req_ready=0 in LOAD, EXEC and FLAG. req_valid is ignored while busy and no request is dropped silently; the requester holds req_valid.
- alu_sel is stable from the accept edge until the next accept.
- flag_out always reflects the flag register, including when flag_oe=0.

Optional Feature:
ALU_SEQ_BACK2BACK_EN:
- Defined: req_ready is also 1 in EXEC and FLAG. A request accepted in those states goes directly to LOAD or FLAG at the next edge, with no IDLE cycle. Flags and A are committed at that same edge, so they are visible to the next operation's LOAD.
- Undefined: behaviour is exactly as above, with a mandatory IDLE cycle between operations.

Test Plan:
- Reset check: pulse rst for 1 cycle -> flag_out=8'h02, req_ready=1, all strobes 0, alu_sel=0.
- ALU_A flag capture: req_sel=5'b10110, ALU inputs msb=0, zero=1, parity=1, carry=1, aux=0 ->
  - LOAD: a_to_act=1 and write_dbus_to_alu_tmp=1.
  - EXEC: alu_to_a=1 and done=1.
  - Result: flag_out=8'h47, alu_sel=5'b10110 throughout.
- ALU_CMP no writeback: same ALU inputs with carry=0 and msb=1 -> alu_to_a stays 0 for the whole op; flag_out=8'hC6.
- INR_DCR: flags preset to 8'h03, req_dec=1, ALU inputs zero=0, parity=0, aux=1, msb=0 ->
  - LOAD: sel_0_fe=1 and fe_0_to_act=1.
  - EXEC: sel_alu_a=1 and alu_a_to_dbus=1.
  - Result: flag_out=8'h13 (CY kept).
- POP then PUSH: POP_PSW with flag_in=8'hFF -> flag_out=8'hD7. Then PUSH_PSW -> flag_oe=1 for exactly 1 cycle with flag_out=8'hD7 and done=1.
- Reset mid-op: rst asserted during LOAD of an ALU_A -> next cycle is IDLE, alu_to_a never asserts, flags=8'h02. With ALU_SEQ_BACK2BACK_EN defined, two back-to-back ALU_A requests complete in 4 cycles.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Request/completion handshake between instruction decode and the ALU sequencer.
// The decoder holds the request fields stable while req_valid is high and not yet accepted.
interface alu_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_kind;
  logic [4:0] req_sel;
  logic       req_dec;
  logic       done;

  modport master (
    output req_valid,
    output req_kind,
    output req_sel,
    output req_dec,
    input  req_ready,
    input  done
  );

  modport slave (
    input  req_valid,
    input  req_kind,
    input  req_sel,
    input  req_dec,
    output req_ready,
    output done
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences ACT/TMP load, ALU select, A writeback and bus drive, and owns the 8085 flag register.
// Optional macro ALU_SEQ_BACK2BACK_EN lets a new request be accepted in the final cycle of an operation.
module alu_sequencer #(
  parameter logic [7:0] FLAG_RESET = 8'h02,
  parameter bit         CY_INV     = 1'b0
) (
  input  logic             phi1,
  input  logic             rst,
  alu_sequencer_if.slave   req_bus,
  output logic [4:0]       alu_sel,
  output logic             dbus_to_act,
  output logic             a_to_act,
  output logic             write_dbus_to_alu_tmp,
  output logic             alu_to_a,
  output logic             sel_alu_a,
  output logic             alu_a_to_dbus,
  output logic             sel_0_fe,
  output logic             fe_0_to_act,
  input  logic             alu_msb,
  input  logic             alu_zero,
  input  logic             alu_parity,
  input  logic             alu_carry,
  input  logic             alu_aux,
  input  logic [7:0]       flag_in,
  output logic [7:0]       flag_out,
  output logic             flag_oe
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_FLAG = 2'd3;

  localparam logic [2:0] K_ALU_A    = 3'd0;
  localparam logic [2:0] K_ALU_CMP  = 3'd1;
  localparam logic [2:0] K_INR_DCR  = 3'd2;
  localparam logic [2:0] K_PUSH_PSW = 3'd3;
  localparam logic [2:0] K_POP_PSW  = 3'd4;

  // Flag byte is {S,Z,0,AC,0,P,1,CY}; bits 5 and 3 read 0 and bit 1 reads 1 whatever is loaded.
  localparam logic [7:0] FLAG_KEEP_MASK = 8'hD7;
  localparam logic [7:0] FLAG_FORCE_ONE = 8'h02;
  localparam logic [7:0] FLAG_RESET_FIX = (FLAG_RESET & FLAG_KEEP_MASK) | FLAG_FORCE_ONE;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] dispatch_state;
  logic [2:0] kind_q;
  logic       dec_q;
  logic [7:0] flags;
  logic [7:0] flags_nxt;
  logic [7:0] alu_flags;
  logic       accept;
  logic       done_w;

`ifdef ALU_SEQ_BACK2BACK_EN
  assign req_bus.req_ready = (state == ST_IDLE) || (state == ST_EXEC) || (state == ST_FLAG);
`else
  assign req_bus.req_ready = (state == ST_IDLE);
`endif

  assign accept         = req_bus.req_valid && req_bus.req_ready;
  assign dispatch_state = (req_bus.req_kind <= K_INR_DCR) ? ST_LOAD : ST_FLAG;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = dispatch_state;
      ST_LOAD: state_nxt = ST_EXEC;
      ST_EXEC,
      ST_FLAG: state_nxt = accept ? dispatch_state : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // INR/DCR leave CY alone; every other ALU kind takes the carry in the configured polarity.
  assign alu_flags = {alu_msb, alu_zero, 1'b0, alu_aux, 1'b0, alu_parity, 1'b1,
                      (kind_q == K_INR_DCR) ? flags[0] : (alu_carry ^ CY_INV)};

  always_comb begin
    flags_nxt = flags;
    if (state == ST_EXEC)
      flags_nxt = alu_flags;
    else if ((state == ST_FLAG) && (kind_q == K_POP_PSW))
      flags_nxt = (flag_in & FLAG_KEEP_MASK) | FLAG_FORCE_ONE;
  end

  always_ff @(posedge phi1) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state   <= ST_IDLE;
      flags   <= FLAG_RESET_FIX;
      alu_sel <= 5'd0;
      kind_q  <= 3'd0;
      dec_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      flags <= flags_nxt;
      if (accept) begin
        kind_q  <= req_bus.req_kind;
        dec_q   <= req_bus.req_dec;
        alu_sel <= req_bus.req_sel;
      end
    end
  end

  always_comb begin
    dbus_to_act           = 1'b0;
    a_to_act              = 1'b0;
    write_dbus_to_alu_tmp = 1'b0;
    alu_to_a              = 1'b0;
    sel_alu_a             = 1'b0;
    alu_a_to_dbus         = 1'b0;
    sel_0_fe              = 1'b0;
    fe_0_to_act           = 1'b0;
    flag_oe               = 1'b0;
    done_w                = 1'b0;
    case (state)
      ST_LOAD: begin
        write_dbus_to_alu_tmp = 1'b1;
        if ((kind_q == K_ALU_A) || (kind_q == K_ALU_CMP))
          a_to_act = 1'b1;
        if (kind_q == K_INR_DCR) begin
          sel_0_fe    = 1'b1;
          fe_0_to_act = dec_q;
        end
      end
      ST_EXEC: begin
        done_w = 1'b1;
        if (kind_q == K_ALU_A)
          alu_to_a = 1'b1;
        if (kind_q == K_INR_DCR) begin
          sel_alu_a     = 1'b1;
          alu_a_to_dbus = 1'b1;
        end
      end
      ST_FLAG: begin
        done_w = 1'b1;
        if (kind_q == K_PUSH_PSW)
          flag_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_bus.done = done_w;
  assign flag_out     = flags;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus random operations
// checked against a transaction-level model of strobe sequences and flag updates.
module tb_alu_sequencer;

  localparam logic [7:0] FLAG_RESET = 8'h02;
  localparam bit         CY_INV     = 1'b0;

  // Bench-side strobe vector layout.
  localparam logic [9:0] V_DBUS2ACT = 10'b10_0000_0000;
  localparam logic [9:0] V_A2ACT    = 10'b01_0000_0000;
  localparam logic [9:0] V_WTMP     = 10'b00_1000_0000;
  localparam logic [9:0] V_ALU2A    = 10'b00_0100_0000;
  localparam logic [9:0] V_SELA     = 10'b00_0010_0000;
  localparam logic [9:0] V_A2DBUS   = 10'b00_0001_0000;
  localparam logic [9:0] V_SEL0FE   = 10'b00_0000_1000;
  localparam logic [9:0] V_FE2ACT   = 10'b00_0000_0100;
  localparam logic [9:0] V_OE       = 10'b00_0000_0010;
  localparam logic [9:0] V_DONE     = 10'b00_0000_0001;

  logic       phi1 = 1'b0;
  logic       rst;
  logic [4:0] alu_sel;
  logic       dbus_to_act, a_to_act, write_dbus_to_alu_tmp, alu_to_a;
  logic       sel_alu_a, alu_a_to_dbus, sel_0_fe, fe_0_to_act;
  logic       alu_msb, alu_zero, alu_parity, alu_carry, alu_aux;
  logic [7:0] flag_in;
  logic [7:0] flag_out;
  logic       flag_oe;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_flags;

  always #5 phi1 = ~phi1;

  alu_sequencer_if req_bus();

  alu_sequencer #(.FLAG_RESET(FLAG_RESET), .CY_INV(CY_INV)) dut (
    .phi1                  (phi1),
    .rst                   (rst),
    .req_bus               (req_bus),
    .alu_sel               (alu_sel),
    .dbus_to_act           (dbus_to_act),
    .a_to_act              (a_to_act),
    .write_dbus_to_alu_tmp (write_dbus_to_alu_tmp),
    .alu_to_a              (alu_to_a),
    .sel_alu_a             (sel_alu_a),
    .alu_a_to_dbus         (alu_a_to_dbus),
    .sel_0_fe              (sel_0_fe),
    .fe_0_to_act           (fe_0_to_act),
    .alu_msb               (alu_msb),
    .alu_zero              (alu_zero),
    .alu_parity            (alu_parity),
    .alu_carry             (alu_carry),
    .alu_aux               (alu_aux),
    .flag_in               (flag_in),
    .flag_out              (flag_out),
    .flag_oe               (flag_oe)
  );

  function automatic logic [9:0] strobes();
    return {dbus_to_act, a_to_act, write_dbus_to_alu_tmp, alu_to_a, sel_alu_a,
            alu_a_to_dbus, sel_0_fe, fe_0_to_act, flag_oe, req_bus.done};
  endfunction

  // Flag byte an ALU op should leave behind, built from the documented bit layout.
  function automatic logic [7:0] alu_result_flags(input logic [2:0] kind, input logic [4:0] ai,
                                                  input logic [7:0] old_flags);
    int   f;
    logic cy;
    cy = (kind == 3'd2) ? old_flags[0] : (ai[1] ^ CY_INV);
    f  = (int'(ai[4]) * 128) + (int'(ai[3]) * 64) + (int'(ai[0]) * 16) + (int'(ai[2]) * 4) + 2 + int'(cy);
    return f[7:0];
  endfunction

  // One complete operation from an idle sequencer; ai = {msb, zero, parity, carry, aux}.
  task automatic run_op(input string name, input logic [2:0] kind, input logic [4:0] sel,
                        input logic dec, input logic [4:0] ai, input logic [7:0] fin);
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic [7:0] exp_flags;
    logic [9:0] v;
    exp_flags = model_flags;
    case (kind)
      3'd0: begin
        exp_q.push_back(V_A2ACT | V_WTMP);
        exp_q.push_back(V_ALU2A | V_DONE);
        exp_flags = alu_result_flags(kind, ai, model_flags);
      end
      3'd1: begin
        exp_q.push_back(V_A2ACT | V_WTMP);
        exp_q.push_back(V_DONE);
        exp_flags = alu_result_flags(kind, ai, model_flags);
      end
      3'd2: begin
        exp_q.push_back(V_WTMP | V_SEL0FE | (dec ? V_FE2ACT : 10'd0));
        exp_q.push_back(V_SELA | V_A2DBUS | V_DONE);
        exp_flags = alu_result_flags(kind, ai, model_flags);
      end
      3'd3: exp_q.push_back(V_OE | V_DONE);
      3'd4: begin
        exp_q.push_back(V_DONE);
        exp_flags = (fin & 8'hD7) | 8'h02;
      end
      default: exp_q.push_back(V_DONE);
    endcase

    @(negedge phi1);
    {alu_msb, alu_zero, alu_parity, alu_carry, alu_aux} = ai;
    flag_in          = fin;
    req_bus.req_kind = kind;
    req_bus.req_sel  = sel;
    req_bus.req_dec  = dec;
    req_bus.req_valid = 1'b1;
    checks++;
    if (req_bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_idle: got %b expected 1", name, req_bus.req_ready);
    end
    @(posedge phi1);
    #1 req_bus.req_valid = 1'b0;

    for (int c = 0; c < 6; c++) begin
      @(negedge phi1);
      v = strobes();
      got_q.push_back(v);
      checks++;
      if (alu_sel !== sel) begin
        errors++;
        $display("FAIL %s alu_sel_c%0d: got %b expected %b", name, c, alu_sel, sel);
      end
      if (flag_oe === 1'b1) begin
        checks++;
        if (flag_out !== model_flags) begin
          errors++;
          $display("FAIL %s push_flags: got %h expected %h", name, flag_out, model_flags);
        end
      end
      if (v[0] === 1'b1) break;
    end

    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s strobes_c%0d: got %b expected %b", name, i, got_q[i], exp_q[i]);
        end
      end
    end

    model_flags = exp_flags;
    @(negedge phi1);
    checks++;
    if ((flag_out !== model_flags) || (req_bus.req_ready !== 1'b1) || (strobes() !== 10'd0) ||
        (alu_sel !== sel)) begin
      errors++;
      $display("FAIL %s after: flags %h ready %b strobes %b sel %b expected flags %h ready 1 strobes 0 sel %b",
               name, flag_out, req_bus.req_ready, strobes(), alu_sel, model_flags, sel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge phi1);
    #1 rst = 1'b0;
    model_flags = 8'h02;
    @(negedge phi1);
    checks++;
    if (flag_out !== 8'h02) begin
      errors++;
      $display("FAIL reset_flags: got %h expected 02", flag_out);
    end
    checks++;
    if ((req_bus.req_ready !== 1'b1) || (strobes() !== 10'd0) || (alu_sel !== 5'd0)) begin
      errors++;
      $display("FAIL reset_outputs: ready %b strobes %b sel %b expected 1 0 0",
               req_bus.req_ready, strobes(), alu_sel);
    end
  endtask

  task automatic test_alu_a();
    run_op("alu_a", 3'd0, 5'b10110, 1'b0, 5'b01110, 8'h00);
    checks++;
    if (flag_out !== 8'h47) begin
      errors++;
      $display("FAIL alu_a_flags: got %h expected 47", flag_out);
    end
  endtask

  task automatic test_alu_cmp();
    run_op("alu_cmp", 3'd1, 5'b10110, 1'b0, 5'b11100, 8'h00);
    checks++;
    if (flag_out !== 8'hC6) begin
      errors++;
      $display("FAIL cmp_flags: got %h expected C6", flag_out);
    end
  endtask

  task automatic test_inr_dcr();
    run_op("preset_pop", 3'd4, 5'b00000, 1'b0, 5'b00000, 8'h01);
    run_op("dcr", 3'd2, 5'b01001, 1'b1, 5'b00001, 8'h00);
    checks++;
    if (flag_out !== 8'h13) begin
      errors++;
      $display("FAIL dcr_flags: got %h expected 13", flag_out);
    end
    run_op("inr", 3'd2, 5'b01000, 1'b0, 5'b11100, 8'h00);
  endtask

  task automatic test_pop_push();
    run_op("pop", 3'd4, 5'b00000, 1'b0, 5'b11111, 8'hFF);
    checks++;
    if (flag_out !== 8'hD7) begin
      errors++;
      $display("FAIL pop_flags: got %h expected D7", flag_out);
    end
    run_op("push", 3'd3, 5'b00000, 1'b0, 5'b00000, 8'h00);
    run_op("nop", 3'd6, 5'b11111, 1'b1, 5'b10101, 8'h28);
  endtask

  task automatic test_reset_mid_op();
    @(negedge phi1);
    {alu_msb, alu_zero, alu_parity, alu_carry, alu_aux} = 5'b10011;
    req_bus.req_kind  = 3'd0;
    req_bus.req_sel   = 5'b11011;
    req_bus.req_dec   = 1'b0;
    req_bus.req_valid = 1'b1;
    @(posedge phi1);
    #1 req_bus.req_valid = 1'b0;
    @(negedge phi1);
    checks++;
    if (a_to_act !== 1'b1) begin
      errors++;
      $display("FAIL midop_load: a_to_act got %b expected 1", a_to_act);
    end
    rst = 1'b1;
    @(posedge phi1);
    #1 rst = 1'b0;
    model_flags = 8'h02;
    for (int c = 0; c < 3; c++) begin
      @(negedge phi1);
      checks++;
      if ((alu_to_a !== 1'b0) || (req_bus.done !== 1'b0) || (req_bus.req_ready !== 1'b1) ||
          (flag_out !== 8'h02) || (alu_sel !== 5'd0)) begin
        errors++;
        $display("FAIL midop_abort_c%0d: alu_to_a %b done %b ready %b flags %h sel %b expected 0 0 1 02 0",
                 c, alu_to_a, req_bus.done, req_bus.req_ready, flag_out, alu_sel);
      end
    end
  endtask

  // Two ALU_A requests with req_valid held; the second completes at cycle 4 with
  // back-to-back acceptance, or cycle 5 with the mandatory idle cycle.
  task automatic test_back_to_back();
    int done_cyc[$];
    int writes;
    int loads;
    int exp_second;
`ifdef ALU_SEQ_BACK2BACK_EN
    exp_second = 4;
`else
    exp_second = 5;
`endif
    writes = 0;
    loads  = 0;
    @(negedge phi1);
    {alu_msb, alu_zero, alu_parity, alu_carry, alu_aux} = 5'b10011;
    req_bus.req_kind  = 3'd0;
    req_bus.req_sel   = 5'b00101;
    req_bus.req_dec   = 1'b0;
    req_bus.req_valid = 1'b1;
    @(posedge phi1);
    #1 req_bus.req_sel = 5'b11010;
    for (int c = 1; c <= 8; c++) begin
      @(negedge phi1);
      if (alu_to_a === 1'b1) writes++;
      if (a_to_act === 1'b1) begin
        loads++;
        if (loads == 2) begin
          req_bus.req_valid = 1'b0;
          {alu_msb, alu_zero, alu_parity, alu_carry, alu_aux} = 5'b01101;
          checks++;
          if (flag_out !== 8'h93) begin
            errors++;
            $display("FAIL b2b_first_flags: got %h expected 93", flag_out);
          end
        end
      end
      if (req_bus.done === 1'b1) done_cyc.push_back(c);
      if (done_cyc.size() == 2) break;
    end
    req_bus.req_valid = 1'b0;
    checks++;
    if ((done_cyc.size() != 2) || (writes != 2)) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses %0d writes expected 2 2", done_cyc.size(), writes);
    end else begin
      checks++;
      if ((done_cyc[0] != 2) || (done_cyc[1] != exp_second)) begin
        errors++;
        $display("FAIL b2b_timing: got done at %0d,%0d expected 2,%0d", done_cyc[0], done_cyc[1], exp_second);
      end
    end
    model_flags = 8'h56;
    @(negedge phi1);
    checks++;
    if ((flag_out !== 8'h56) || (alu_sel !== 5'b11010)) begin
      errors++;
      $display("FAIL b2b_result: flags %h sel %b expected 56 11010", flag_out, alu_sel);
    end
  endtask

  task automatic test_random();
    logic [2:0] kind;
    for (int n = 0; n < 40; n++) begin
      kind = 3'($urandom_range(0, 7));
      run_op("random", kind, 5'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    rst               = 1'b1;
    req_bus.req_valid = 1'b0;
    req_bus.req_kind  = 3'd0;
    req_bus.req_sel   = 5'd0;
    req_bus.req_dec   = 1'b0;
    {alu_msb, alu_zero, alu_parity, alu_carry, alu_aux} = 5'd0;
    flag_in     = 8'h00;
    model_flags = 8'h02;

    test_reset();
    test_alu_a();
    test_alu_cmp();
    test_inr_dcr();
    test_pop_push();
    test_reset_mid_op();
    test_back_to_back();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
